spio_hss_multiplexer_tx_framer: RTL

Parametrised transmit framer for the HSS multiplexer link. It sits between the frame assembler's 32-bit word stream and the transceiver TX port. It inserts handshake words, clock-correction bursts and idle frames, optionally scrambled. Unlike its predecessor, it honours the vld/rdy protocol strictly, so an offered word is never lost or duplicated. The clock-correction interval is programmable at run time, and burst length is a parameter.

---
 rtl/spio_hss_multiplexer_tx_framer_pkg.sv | 49 ++++
 rtl/spio_hss_multiplexer_lfsr.sv | 24 ++
 rtl/spio_hss_multiplexer_tx_framer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/spio_hss_multiplexer_tx_framer_pkg.sv
// Shared constants, word type and state encoding for the HSS multiplexer TX framer
// and for the RX-side monitors that decode its state.
package spio_hss_multiplexer_tx_framer_pkg;

    localparam int unsigned WORD_BITS     = 32;
    localparam int unsigned KBITS         = 4;
    localparam int unsigned IDLE_BITS     = 24;
    localparam int unsigned CC_COUNT_BITS = 16;

    localparam logic [7:0] KCH_COMMA        = 8'hBC;
    localparam logic [7:0] KCH_HANDSHAKE    = 8'h7C;
    localparam logic [7:0] KCH_IDLE         = 8'h1C;
    localparam logic [7:0] KCH_CLKC         = 8'hF7;
    localparam logic [7:0] PROTOCOL_VERSION = 8'h02;

    localparam logic [KBITS-1:0]     IDLE_KBITS = 4'b1000;
    localparam logic [IDLE_BITS-1:0] LFSR_SEED  = 24'hACE1A5;

    // State encoding, also used by the RX-side monitors
    localparam logic [1:0] TX_STATE_HSHK = 2'd0;
    localparam logic [1:0] TX_STATE_DATA = 2'd1;
    localparam logic [1:0] TX_STATE_CLKC = 2'd2;

    typedef enum logic [1:0] {
        ST_HSHK = TX_STATE_HSHK,
        ST_DATA = TX_STATE_DATA,
        ST_CLKC = TX_STATE_CLKC
    } tx_state_t;

    typedef struct packed {
        logic [WORD_BITS-1:0] data;
        logic [KBITS-1:0]     k;
    } tx_word_t;

    function automatic tx_word_t handshake_word(input logic phase);
        tx_word_t w;
        w.data = {KCH_COMMA, KCH_HANDSHAKE, 7'd0, phase, PROTOCOL_VERSION};
        w.k    = 4'b1100;
        return w;
    endfunction

    function automatic tx_word_t clkc_word();
        tx_word_t w;
        w.data = {4{KCH_CLKC}};
        w.k    = 4'b1111;
        return w;
    endfunction

endpackage

// File: rtl/spio_hss_multiplexer_lfsr.sv
// Idle-payload scrambler: 24-bit Fibonacci LFSR (x^24+x^23+x^22+x^17+1), steps only when told.
module spio_hss_multiplexer_lfsr
    import spio_hss_multiplexer_tx_framer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 advance,
    output logic [IDLE_BITS-1:0] dat
);

    logic [IDLE_BITS-1:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (advance) begin
            lfsr <= {lfsr[IDLE_BITS-2:0],
                     lfsr[23] ^ lfsr[22] ^ lfsr[21] ^ lfsr[16]};
        end
    end

    assign dat = lfsr;

endmodule

// File: rtl/spio_hss_multiplexer_tx_framer.sv
// Transmit framer: handshake words, data/idle frames and periodic clock-correction
// bursts onto the transceiver TX port, with a lossless vld/rdy input.
module spio_hss_multiplexer_tx_framer
    import spio_hss_multiplexer_tx_framer_pkg::*;
#(
    parameter int unsigned CC_BURST = 1,
    parameter int unsigned CCI_BITS = 16
) (
    input  logic                     CLK_IN,
    input  logic                     RESET_IN,
    input  logic                     SCRMBL_IDL_DAT,
    input  logic [IDLE_BITS-1:0]     REG_IDSO_IN,
    input  logic [CCI_BITS-1:0]      REG_CCI_IN,
    input  logic                     HANDSHAKE_COMPLETE_IN,
    input  logic                     HANDSHAKE_PHASE_IN,
    output logic [WORD_BITS-1:0]     TXDATA_OUT,
    output logic [KBITS-1:0]         TXCHARISK_OUT,
    input  logic [WORD_BITS-1:0]     TXDATA_IN,
    input  logic [KBITS-1:0]         TXCHARISK_IN,
    input  logic                     TXVLD_IN,
    output logic                     TXRDY_OUT,
    output logic [CC_COUNT_BITS-1:0] CC_COUNT_OUT
);

    localparam int unsigned BW = 4;
    localparam logic [BW-1:0] BURST_LAST = BW'(CC_BURST - 1);

    tx_state_t                  state;
    tx_state_t                  state_d;
    tx_word_t                   word_q;
    tx_word_t                   word_d;
    logic [CCI_BITS-1:0]        cci_cnt;
    logic                       cci_en;
    logic                       cci_load_req;
    logic [BW-1:0]              burst_idx;
    logic [CC_COUNT_BITS-1:0]   cc_count;
    logic                       cc_pending;
    logic                       burst_last;
    logic                       accept;
    logic                       cc_enter;
    logic                       lfsr_adv;
    logic [IDLE_BITS-1:0]       lfsr_dat;
    logic [IDLE_BITS-1:0]       idle;

    // A burst is owed once the interval counter has run down to zero
    assign cc_pending = cci_en && (cci_cnt == '0);
    assign TXRDY_OUT  = (state == ST_DATA) && !cc_pending && HANDSHAKE_COMPLETE_IN;
    assign accept     = TXVLD_IN && TXRDY_OUT;
    assign burst_last = (state == ST_CLKC) && (burst_idx == BURST_LAST);
    assign cc_enter   = cc_pending && ((state != ST_CLKC) || burst_last);
    assign lfsr_adv   = (state == ST_DATA) && !accept && SCRMBL_IDL_DAT;
    assign idle       = SCRMBL_IDL_DAT ? lfsr_dat : REG_IDSO_IN;

    spio_hss_multiplexer_lfsr u_lfsr (
        .clk     (CLK_IN),
        .rst_n   (RESET_IN),
        .advance (lfsr_adv),
        .dat     (lfsr_dat)
    );

    // Next state and next output word
    always_comb begin
        state_d = state;
        word_d  = '0;
        case (state)
            ST_HSHK: begin
                word_d = handshake_word(HANDSHAKE_PHASE_IN);
                if (cc_pending) begin
                    state_d = ST_CLKC;
                end else if (HANDSHAKE_COMPLETE_IN) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    word_d.data = TXDATA_IN;
                    word_d.k    = TXCHARISK_IN;
                end else begin
                    word_d.data = {KCH_IDLE, idle};
                    word_d.k    = IDLE_KBITS;
                end
                if (cc_pending) begin
                    state_d = ST_CLKC;
                end else if (!HANDSHAKE_COMPLETE_IN) begin
                    state_d = ST_HSHK;
                end
            end
            ST_CLKC: begin
                word_d = clkc_word();
                if (burst_last) begin
                    if (cc_pending) begin
                        state_d = ST_CLKC;
                    end else if (HANDSHAKE_COMPLETE_IN) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_HSHK;
                    end
                end
            end
            default: state_d = ST_HSHK;
        endcase
    end

    // State, output word, interval counter and burst bookkeeping
    always_ff @(posedge CLK_IN or negedge RESET_IN) begin
        if (!RESET_IN) begin
            state        <= ST_HSHK;
            word_q       <= '0;
            cci_cnt      <= '0;
            cci_en       <= 1'b0;
            cci_load_req <= 1'b1;
            burst_idx    <= '0;
            cc_count     <= '0;
        end else begin
            state  <= state_d;
            word_q <= word_d;

            // First cycle out of reset reloads, as does every burst start
            if (cci_load_req || cc_enter) begin
                cci_cnt      <= REG_CCI_IN - CCI_BITS'(1);
                cci_en       <= (REG_CCI_IN != '0);
                cci_load_req <= 1'b0;
            end else if (cci_en && (cci_cnt != '0)) begin
                cci_cnt <= cci_cnt - CCI_BITS'(1);
            end

            if (state == ST_CLKC) begin
                if (burst_last) begin
                    burst_idx <= '0;
                    if (cc_count != '1) begin
                        cc_count <= cc_count + CC_COUNT_BITS'(1);
                    end
                end else begin
                    burst_idx <= burst_idx + BW'(1);
                end
            end
        end
    end

    assign TXDATA_OUT    = word_q.data;
    assign TXCHARISK_OUT = word_q.k;
    assign CC_COUNT_OUT  = cc_count;

endmodule
